// File: rtl/instr_fetch_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_fetch_sequencer_if                                      |
// | Purpose  : Program-load / control and instruction-issue bundle between    |
// |            a controller (master) and the fetch sequencer (slave).         |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface instr_fetch_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] pc_o;
  logic              instr_valid;
  logic [1:0]        beat_o;
  logic              busy;
  logic              halted;

  modport master (
    output start, prog_we, prog_addr, prog_data,
    input  instruction, pc_o, instr_valid, beat_o, busy, halted
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data,
    output instruction, pc_o, instr_valid, beat_o, busy, halted
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_fetch_sequencer                                         |
// | Purpose  : Instruction memory plus issue sequencer feeding the processor; |
// |            vector loads/stores are held for VEC_BEATS cycles.            |
// |            Optional fetch trace under macro FETCH_TRACE_EN.              |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module instr_fetch_sequencer #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 6,
  parameter int VEC_BEATS  = 4
) (
  input  wire                          clk,
  input  wire                          reset,
  instr_fetch_sequencer_if.slave       bus
);

  localparam logic [31:0]       c_halt_word = 32'hFFFF_FFFF;
  localparam logic [5:0]        c_op_vld    = 6'b111000;
  localparam logic [5:0]        c_op_vst    = 6'b111100;
  localparam logic [1:0]        c_last_beat = 2'(VEC_BEATS - 1);
  localparam logic [ADDR_W-1:0] c_pc_one    = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_imem [IMEM_DEPTH];
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic [1:0]        r_beat;

  logic [31:0]       w_instr_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_valid_nxt;
  logic [1:0]        w_beat_nxt;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic [31:0]       w_fetch_word;
  logic              w_fetch_halt;
  logic              w_is_vec;
  logic              w_stopped;

  assign w_stopped    = (r_state == ST_IDLE) || (r_state == ST_HALT);
  assign w_is_vec     = (r_instr[31:26] == c_op_vld) || (r_instr[31:26] == c_op_vst);
  // Read sees the pre-edge contents, so a same-cycle write is not bypassed.
  assign w_fetch_word = r_imem[w_fetch_addr];
  assign w_fetch_halt = (w_fetch_word == c_halt_word);

  // Program loading is only permitted while nothing is executing.
  always_ff @(posedge clk) begin
    if (bus.prog_we && w_stopped) begin
      r_imem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_instr_nxt  = r_instr;
    w_pc_nxt     = r_pc;
    w_valid_nxt  = r_valid;
    w_beat_nxt   = r_beat;
    w_fetch      = 1'b0;
    w_fetch_addr = r_pc + c_pc_one;

    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          w_fetch      = 1'b1;
          w_fetch_addr = '0;
        end
      end
      ST_ISSUE: begin
        if (w_is_vec) begin
          w_state_nxt = ST_HOLD;
          w_beat_nxt  = 2'd1;
        end else begin
          w_fetch = 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_beat == c_last_beat) begin
          w_fetch = 1'b1;
        end else begin
          w_beat_nxt = r_beat + 2'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_fetch) begin
      w_pc_nxt   = w_fetch_addr;
      w_beat_nxt = 2'd0;
      if (w_fetch_halt) begin
        w_state_nxt = ST_HALT;
        w_instr_nxt = 32'd0;
        w_valid_nxt = 1'b0;
      end else begin
        w_state_nxt = ST_ISSUE;
        w_instr_nxt = w_fetch_word;
        w_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_instr <= 32'd0;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_beat  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_instr <= w_instr_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && w_fetch) begin
      if (w_fetch_halt) begin
        $display("FETCH HALT pc=%0d", w_fetch_addr);
      end else begin
        $display("FETCH pc=%0d instr=%b beat=%0d", w_fetch_addr, w_fetch_word, w_beat_nxt);
      end
    end
  end
`else
`endif

  assign bus.instruction = r_instr;
  assign bus.pc_o        = r_pc;
  assign bus.instr_valid = r_valid;
  assign bus.beat_o      = r_beat;
  assign bus.busy        = (r_state == ST_ISSUE) || (r_state == ST_HOLD);
  assign bus.halted      = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instr_fetch_sequencer                                      |
// | Purpose  : Directed self-checking bench for instr_fetch_sequencer.        |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_sequencer;

  localparam logic [31:0] c_add  = 32'b01010100000001000011110000111100;
  localparam logic [31:0] c_ld   = 32'b11000000000001000000110000111100;
  localparam logic [31:0] c_vld  = 32'b11100000000001000000010000111100;
  localparam logic [31:0] c_vst  = 32'b11110000000001000000010000111100;
  localparam logic [31:0] c_halt = 32'hFFFF_FFFF;
  localparam logic [31:0] c_nop  = 32'h0;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  instr_fetch_sequencer_if #(.ADDR_W(6)) bus ();

  instr_fetch_sequencer #(
    .IMEM_DEPTH (64),
    .ADDR_W     (6),
    .VEC_BEATS  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All observable outputs packed together; every field is zero after reset.
  function automatic logic [63:0] all_outs();
    return 64'({bus.instruction, bus.pc_o, bus.instr_valid, bus.beat_o, bus.busy, bus.halted});
  endfunction

  task automatic load(input int addr, input logic [31:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 6'(addr);
    bus.prog_data = data;
    step();
    bus.prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    step();
    step();
    reset = 1'b0;
    check("reset_outs", all_outs(), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_outs", all_outs(), 64'd0);
    end

    // Scalar program ending in HALT
    load(0, c_add);
    load(1, c_ld);
    load(2, c_halt);
    pulse_start();
    check("s1_instr", bus.instruction, c_add);
    check("s1_pc",    bus.pc_o, 0);
    check("s1_valid", bus.instr_valid, 1);
    check("s1_busy",  bus.busy, 1);
    step();
    check("s2_instr", bus.instruction, c_ld);
    check("s2_pc",    bus.pc_o, 1);
    step();
    check("s3_halted", bus.halted, 1);
    check("s3_valid",  bus.instr_valid, 0);
    check("s3_instr",  bus.instruction, 0);
    check("s3_busy",   bus.busy, 0);

    // Vector hold: VLD then VST, each for four beats
    load(0, c_vld);
    load(1, c_vst);
    load(2, c_halt);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("vld_instr", bus.instruction, c_vld);
      check("vld_pc",    bus.pc_o, 0);
      check("vld_beat",  bus.beat_o, 64'(i));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      check("vst_instr", bus.instruction, c_vst);
      check("vst_pc",    bus.pc_o, 1);
      check("vst_beat",  bus.beat_o, 64'(i));
      step();
    end
    check("v9_halted", bus.halted, 1);
    check("v9_valid",  bus.instr_valid, 0);

    // PC wrap with an all-NOP memory
    for (int a = 0; a < 64; a++) begin
      load(a, c_nop);
    end
    pulse_start();
    check("wrap_pc_start", bus.pc_o, 0);
    repeat (63) step();
    check("wrap_pc63",  bus.pc_o, 63);
    check("wrap_busy63", bus.busy, 1);
    step();
    check("wrap_pc0",   bus.pc_o, 0);
    check("wrap_busy0", bus.busy, 1);
    check("wrap_valid", bus.instr_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_issue", all_outs(), 64'd0);

    // Reset during a vector hold
    load(0, c_vld);
    load(1, c_vst);
    load(2, c_halt);
    pulse_start();
    step();
    step();
    check("hold_beat2", bus.beat_o, 2);
    check("hold_busy",  bus.busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_hold", all_outs(), 64'd0);
    pulse_start();
    check("restart_instr", bus.instruction, c_vld);
    check("restart_pc",    bus.pc_o, 0);
    check("restart_beat",  bus.beat_o, 0);
    check("restart_valid", bus.instr_valid, 1);
    repeat (8) step();
    check("restart_halted", bus.halted, 1);

    // Writes while running are dropped; writes in HALT land
    load(0, c_add);
    load(1, c_ld);
    load(2, c_halt);
    pulse_start();
    bus.prog_we   = 1'b1;
    bus.prog_addr = 6'd1;
    bus.prog_data = c_nop;
    step();
    bus.prog_we   = 1'b0;
    check("run_we_instr", bus.instruction, c_ld);
    step();
    check("run_we_halted", bus.halted, 1);
    pulse_start();
    step();
    check("run_we_dropped", bus.instruction, c_ld);
    step();
    check("run_we_halted2", bus.halted, 1);
    load(1, c_nop);
    pulse_start();
    step();
    check("halt_we_instr", bus.instruction, c_nop);
    check("halt_we_pc",    bus.pc_o, 1);
    check("halt_we_valid", bus.instr_valid, 1);
    step();
    check("halt_we_halted", bus.halted, 1);

    // Start and write to address 0 together: fetch returns the old word
    bus.prog_we   = 1'b1;
    bus.prog_addr = 6'd0;
    bus.prog_data = c_nop;
    bus.start     = 1'b1;
    step();
    bus.prog_we   = 1'b0;
    bus.start     = 1'b0;
    check("same_cyc_old", bus.instruction, c_add);
    check("same_cyc_pc",  bus.pc_o, 0);
    step();
    step();
    check("same_cyc_halted", bus.halted, 1);
    pulse_start();
    check("same_cyc_new",   bus.instruction, c_nop);
    check("same_cyc_valid", bus.instr_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Upstream fetch stage for the SISD custom-ISA `processor`. It holds a small program in instruction memory, loaded through a write port. It drives the `instruction` input of `processor` one word at a time. For vector memory instructions (VLD/VST), it holds the word stable for `VEC_BEATS` cycles so the processor's 2-bit beat counter can move the 128-bit register through 32-bit memory.

## Interface
- `IMEM_DEPTH`, default 64: number of 32-bit instruction words.
- `ADDR_W`, default 6: PC width, equal to log2(`IMEM_DEPTH`).
- `VEC_BEATS`, default 4: hold cycles per vector instruction, equal to 128/32.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle pulse that begins execution at PC 0. Honoured only in IDLE or HALT.
- `prog_we`  in  1: instruction-memory write enable. Honoured only in IDLE or HALT.
- `prog_addr`  in  `ADDR_W`: write address.
- `prog_data`  in  32: write data.
- `instruction`  out  32: registered; feeds `processor.instruction`.
- `pc_o`  out  `ADDR_W`: address of the word currently on `instruction`.
- `instr_valid`  out  1: `instruction` holds a fetched word.
- `beat_o`  out  2: vector beat index 0..`VEC_BEATS`-1; 0 for scalar instructions.
- `busy`  out  1: high in ISSUE and HOLD.
- `halted`  out  1: high in HALT.

## Operation
- Decode, using bits [31:26] only:
  - `111000` = VLD and `111100` = VST are vector instructions.
  - `32'hFFFF_FFFF` is HALT.
  - Every other word is scalar (ADD reg/imm, LD, ST, NOP = `32'h0`).
- States:
  - IDLE: outputs are at their reset values.
    - `start` → ISSUE, and PC 0 is fetched.
  - ISSUE: presents one word per cycle.
    - Scalar word: the next edge fetches PC+1.
    - Vector word: the next edge enters HOLD with `beat_o`=1.
  - HOLD: `instruction` and `pc_o` are frozen, and `beat_o` increments each edge.
    - On the edge where `beat_o`=`VEC_BEATS`-1, PC+1 is fetched and the state returns to ISSUE.
  - HALT: entered when the word being fetched equals HALT. The HALT word is never presented.
    - Outputs: `instruction`=0, `instr_valid`=0, `halted`=1.
    - `start` → ISSUE, and PC 0 is fetched.
- Fetch means `instruction`<=imem[addr], `pc_o`<=addr and `instr_valid`<=1. HALT detection uses the fetched word combinationally.
- PC wraps from `IMEM_DEPTH`-1 to 0 with no flag.
- `prog_we` in IDLE or HALT writes imem[`prog_addr`] at the edge. It is ignored in ISSUE and HOLD, because writes are not allowed while the program is running.
- If `start` and `prog_we` are high on the same cycle in IDLE, the write lands and the fetch of PC 0 also occurs. If `prog_addr`=0, the fetch returns the old word; there is no bypass.
- `start` in ISSUE or HOLD is ignored.

## Timing
- Reset values: `instruction`=0, `pc_o`=0, `instr_valid`=0, `beat_o`=0, `busy`=0, `halted`=0, state=IDLE. Instruction-memory contents are not reset.
- `reset` during ISSUE or HOLD aborts at the next edge: state goes to IDLE and all outputs take their reset values.
- Start latency: word 0 appears one cycle after the `start` edge.
- Scalar throughput: 1 word per cycle.
- Vector occupancy: exactly `VEC_BEATS` cycles, with `beat_o`=0,1,2,3, before the next word appears.
- A vector word followed directly by HALT: `halted` rises the cycle after `beat_o`=3.
- Memory write to readback: a word written at edge N can be fetched at edge N+1.

## Configuration
- `FETCH_TRACE_EN`:
  - When defined, each fetch edge issues `$display("FETCH pc=%0d instr=%b beat=%0d", ...)`, and entry to HALT prints `FETCH HALT pc=%0d`.
  - When undefined, no display code is compiled.
  - Synthesised behaviour is identical in both cases.

## Test plan
- Reset, then hold idle for 3 cycles: all outputs remain 0 and `busy`=0.
- Load [0]=`32'b01010100000001000011110000111100` (ADD r0,15), [1]=`32'b11000000000001000000110000111100` (LD r0,[3]), [2]=HALT, then pulse `start`:
  - Cycle 1: `instruction`=ADD, `pc_o`=0.
  - Cycle 2: `instruction`=LD, `pc_o`=1.
  - Cycle 3: `halted`=1, `instr_valid`=0.
- Load [0]=VLD `32'b11100000000001000000010000111100`, [1]=VST `32'b11110000000001000000010000111100`, [2]=HALT:
  - VLD is held for 4 cycles with `beat_o` 0..3.
  - VST is then held for 4 cycles with `beat_o` 0..3.
  - `halted` rises at cycle 9.
- Fill all 64 words with NOP except [63]=NOP and [0]=NOP, with no HALT: after 64 cycles `pc_o` wraps 63→0 and `busy` stays 1.
- Assert `reset` on `beat_o`=2 of a VLD: the next cycle shows all outputs 0 and IDLE. A `start` pulse then re-presents PC 0 with `beat_o`=0.
- Pulse `prog_we` during ISSUE with [1]=`32'h0`: the original [1] word is still issued. After HALT, the same write succeeds, and a restart issues NOP at PC 1.
